// File: rtl/motion_detect_stream.sv
// motion_detect_stream: three-stage, stall-aware motion highlighter.
// Pops matched background/frame pixels from FWFT FIFOs, converts both to
// gray, flags pixels whose gray difference exceeds a runtime threshold and
// writes the frame pixel (or HIGHLIGHT when flagged) to the output FIFO.
// Tracks frame geometry and reports the per-frame motion-pixel count.
// Optional feature macro: MOTION_BG_UPDATE_EN adds a running-average
// background write-back port (bg_upd_*) that also participates in stall.
module motion_detect_stream #(
  parameter int PIX_BITS   = 8,
  parameter int IMG_WIDTH  = 720,
  parameter int IMG_HEIGHT = 540,
  parameter int CNT_BITS   = 20,
  parameter logic [3*PIX_BITS-1:0] HIGHLIGHT = {{PIX_BITS{1'b1}}, {2*PIX_BITS{1'b0}}}
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [PIX_BITS-1:0]   threshold,
  input  logic [3*PIX_BITS-1:0] bg_dout,
  input  logic                  bg_empty,
  output logic                  bg_rd_en,
  input  logic [3*PIX_BITS-1:0] fr_dout,
  input  logic                  fr_empty,
  output logic                  fr_rd_en,
`ifdef MOTION_BG_UPDATE_EN
  output logic [3*PIX_BITS-1:0] bg_upd_din,
  input  logic                  bg_upd_full,
  output logic                  bg_upd_wr_en,
`endif
  output logic [3*PIX_BITS-1:0] out_din,
  input  logic                  out_full,
  output logic                  out_wr_en,
  output logic                  frame_done,
  output logic [CNT_BITS-1:0]   motion_count
);

  localparam int PIX_W = 3 * PIX_BITS;
  localparam int SUM_W = PIX_BITS + 2;
  localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

  // Gray level as the truncated mean of the three channels.
  function automatic logic [PIX_BITS-1:0] gray_of(input logic [PIX_W-1:0] pix);
    logic [SUM_W-1:0] sum;
    sum = SUM_W'(pix[2*PIX_BITS +: PIX_BITS]) + SUM_W'(pix[PIX_BITS +: PIX_BITS])
        + SUM_W'(pix[0 +: PIX_BITS]);
    return PIX_BITS'(sum / SUM_W'(3));
  endfunction

  // Magnitude of the signed difference of two gray levels.
  function automatic logic [PIX_BITS-1:0] abs_diff(input logic [PIX_BITS-1:0] a,
                                                   input logic [PIX_BITS-1:0] b);
    logic signed [PIX_BITS:0] d;
    d = $signed({1'b0, a}) - $signed({1'b0, b});
    return (d < 0) ? PIX_BITS'(-d) : PIX_BITS'(d);
  endfunction

  // Saturating increment of the motion accumulator.
  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] acc,
                                                  input logic inc);
    if (inc && (acc != {CNT_BITS{1'b1}})) return acc + CNT_BITS'(1);
    return acc;
  endfunction

`ifdef MOTION_BG_UPDATE_EN
  // Running average per channel: (3*bg + fr) / 4, truncated.
  function automatic logic [PIX_W-1:0] bg_blend(input logic [PIX_W-1:0] bg,
                                                input logic [PIX_W-1:0] fr);
    logic [PIX_W-1:0] res;
    logic [SUM_W-1:0] t;
    res = '0;
    for (int c = 0; c < 3; c++) begin
      t = (SUM_W'(bg[c*PIX_BITS +: PIX_BITS]) << 1) + SUM_W'(bg[c*PIX_BITS +: PIX_BITS])
        + SUM_W'(fr[c*PIX_BITS +: PIX_BITS]);
      res[c*PIX_BITS +: PIX_BITS] = t[SUM_W-1:2];
    end
    return res;
  endfunction
`endif

  logic stall, advance, pop, wr, last_pix;

  // control state
  logic                vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d, vld_p3_q, vld_p3_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [ROW_W-1:0]    row_q, row_d;
  logic [CNT_BITS-1:0] acc_q, acc_d, mc_q, mc_d;
  logic                fd_q, fd_d;

  // datapath state
  logic [PIX_BITS-1:0] gray_fr_p1_q, gray_fr_p1_d, gray_bg_p1_q, gray_bg_p1_d;
  logic [PIX_W-1:0]    fr_p1_q, fr_p1_d;
  logic                mask_p2_q, mask_p2_d;
  logic [PIX_W-1:0]    fr_p2_q, fr_p2_d;
  logic                mask_p3_q, mask_p3_d;
  logic [PIX_W-1:0]    pix_p3_q, pix_p3_d;
`ifdef MOTION_BG_UPDATE_EN
  logic [PIX_W-1:0]    bg_p1_q, bg_p1_d, upd_p2_q, upd_p2_d, upd_p3_q, upd_p3_d;
`endif

`ifdef MOTION_BG_UPDATE_EN
  assign stall = out_full | bg_upd_full;
`else
  assign stall = out_full;
`endif
  assign advance  = ~vld_p3_q | ~stall;
  // Pops stay quiet while reset is held so no pixel is lost from the FIFOs.
  assign pop      = reset & ~bg_empty & ~fr_empty & advance;
  assign wr       = vld_p3_q & ~stall;
  assign last_pix = wr && (col_q == COL_W'(IMG_WIDTH - 1)) && (row_q == ROW_W'(IMG_HEIGHT - 1));

  // Next-state for valid bits, pixel position, accumulator and frame report.
  always_comb begin
    vld_p1_d = vld_p1_q;
    vld_p2_d = vld_p2_q;
    vld_p3_d = vld_p3_q;
    col_d    = col_q;
    row_d    = row_q;
    acc_d    = acc_q;
    mc_d     = mc_q;
    fd_d     = 1'b0;
    if (advance) begin
      vld_p1_d = pop;
      vld_p2_d = vld_p1_q;
      vld_p3_d = vld_p2_q;
    end
    if (wr) begin
      if (col_q == COL_W'(IMG_WIDTH - 1)) begin
        col_d = '0;
        row_d = (row_q == ROW_W'(IMG_HEIGHT - 1)) ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
      acc_d = sat_inc(acc_q, mask_p3_q);
    end
    if (last_pix) begin
      mc_d  = sat_inc(acc_q, mask_p3_q);
      acc_d = '0;
      fd_d  = 1'b1;
    end
  end

  // Next-state for the pixel datapath; every stage holds while stalled.
  always_comb begin
    gray_fr_p1_d = gray_fr_p1_q;
    gray_bg_p1_d = gray_bg_p1_q;
    fr_p1_d      = fr_p1_q;
    mask_p2_d    = mask_p2_q;
    fr_p2_d      = fr_p2_q;
    mask_p3_d    = mask_p3_q;
    pix_p3_d     = pix_p3_q;
`ifdef MOTION_BG_UPDATE_EN
    bg_p1_d      = bg_p1_q;
    upd_p2_d     = upd_p2_q;
    upd_p3_d     = upd_p3_q;
`endif
    // S1: gray conversion of both streams, raw pixels kept
    if (pop) begin
      gray_fr_p1_d = gray_of(fr_dout);
      gray_bg_p1_d = gray_of(bg_dout);
      fr_p1_d      = fr_dout;
`ifdef MOTION_BG_UPDATE_EN
      bg_p1_d      = bg_dout;
`endif
    end
    if (advance) begin
      // S2: difference against the live threshold
      mask_p2_d = abs_diff(gray_fr_p1_q, gray_bg_p1_q) > threshold;
      fr_p2_d   = fr_p1_q;
`ifdef MOTION_BG_UPDATE_EN
      upd_p2_d  = bg_blend(bg_p1_q, fr_p1_q);
`endif
      // S3: highlight selection
      mask_p3_d = mask_p2_q;
      pix_p3_d  = mask_p2_q ? HIGHLIGHT : fr_p2_q;
`ifdef MOTION_BG_UPDATE_EN
      upd_p3_d  = upd_p2_q;
`endif
    end
  end

  // Control registers, cleared asynchronously so in-flight pixels are dropped.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
      vld_p3_q <= 1'b0;
      col_q    <= '0;
      row_q    <= '0;
      acc_q    <= '0;
      mc_q     <= '0;
      fd_q     <= 1'b0;
    end else begin
      vld_p1_q <= vld_p1_d;
      vld_p2_q <= vld_p2_d;
      vld_p3_q <= vld_p3_d;
      col_q    <= col_d;
      row_q    <= row_d;
      acc_q    <= acc_d;
      mc_q     <= mc_d;
      fd_q     <= fd_d;
    end
  end

  // Datapath registers; contents are qualified by the valid bits.
  always_ff @(posedge clock) begin
    gray_fr_p1_q <= gray_fr_p1_d;
    gray_bg_p1_q <= gray_bg_p1_d;
    fr_p1_q      <= fr_p1_d;
    mask_p2_q    <= mask_p2_d;
    fr_p2_q      <= fr_p2_d;
    mask_p3_q    <= mask_p3_d;
    pix_p3_q     <= pix_p3_d;
`ifdef MOTION_BG_UPDATE_EN
    bg_p1_q      <= bg_p1_d;
    upd_p2_q     <= upd_p2_d;
    upd_p3_q     <= upd_p3_d;
`endif
  end

  assign bg_rd_en     = pop;
  assign fr_rd_en     = pop;
  assign out_wr_en    = wr;
  assign out_din      = vld_p3_q ? pix_p3_q : '0;
  assign frame_done   = fd_q;
  assign motion_count = mc_q;
`ifdef MOTION_BG_UPDATE_EN
  assign bg_upd_wr_en = wr;
  assign bg_upd_din   = vld_p3_q ? upd_p3_q : '0;
`endif

endmodule

// File: tb/tb_motion_detect_stream.sv
// Directed bench for motion_detect_stream with a 4x2 frame geometry.
// FWFT FIFOs are modelled with queues; outputs are sampled on the falling edge.
module tb_motion_detect_stream;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [7:0]  threshold;
  logic [23:0] bg_dout, fr_dout;
  logic        bg_empty, fr_empty, out_full;
  logic        bg_rd_en, fr_rd_en, out_wr_en, frame_done;
  logic [23:0] out_din;
  logic [19:0] motion_count;
`ifdef MOTION_BG_UPDATE_EN
  logic [23:0] bg_upd_din;
  logic        bg_upd_full, bg_upd_wr_en;
`endif

  always #5 clock = ~clock;

  motion_detect_stream #(.IMG_WIDTH(4), .IMG_HEIGHT(2)) dut (
    .clock(clock), .reset(reset), .threshold(threshold),
    .bg_dout(bg_dout), .bg_empty(bg_empty), .bg_rd_en(bg_rd_en),
    .fr_dout(fr_dout), .fr_empty(fr_empty), .fr_rd_en(fr_rd_en),
`ifdef MOTION_BG_UPDATE_EN
    .bg_upd_din(bg_upd_din), .bg_upd_full(bg_upd_full), .bg_upd_wr_en(bg_upd_wr_en),
`endif
    .out_din(out_din), .out_full(out_full), .out_wr_en(out_wr_en),
    .frame_done(frame_done), .motion_count(motion_count)
  );

  localparam logic [23:0] HL = 24'hFF0000;

  logic [23:0] bg_q[$], fr_q[$], exp_q[$], got_q[$], upd_exp_q[$], upd_got_q[$];
  bit          exp_mask_q[$];
  int checks = 0, errors = 0;
  int cyc_n = 0, first_rd, first_wr, fd_cnt, fd_at, last_mc;
  bit hold_fr = 0, bp_en = 0, upd_hold = 0;
  logic s_rd, s_fr, s_wr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int gray(input logic [23:0] p);
    return (int'(p[23:16]) + int'(p[15:8]) + int'(p[7:0])) / 3;
  endfunction

  task automatic push(input logic [23:0] fr, input logic [23:0] bg);
    int d;
    bit m;
    logic [23:0] u;
    d = gray(fr) - gray(bg);
    if (d < 0) d = -d;
    m = (d > int'(threshold));
    for (int c = 0; c < 3; c++) u[c*8 +: 8] = 8'((3 * int'(bg[c*8 +: 8]) + int'(fr[c*8 +: 8])) / 4);
    fr_q.push_back(fr);
    bg_q.push_back(bg);
    exp_q.push_back(m ? HL : fr);
    exp_mask_q.push_back(m);
    upd_exp_q.push_back(u);
  endtask

  task automatic drive();
    bg_empty = (bg_q.size() == 0);
    fr_empty = (fr_q.size() == 0) || hold_fr;
    bg_dout  = (bg_q.size() != 0) ? bg_q[0] : 24'h0;
    fr_dout  = (fr_q.size() != 0) ? fr_q[0] : 24'h0;
    out_full = bp_en ? 1'($urandom_range(0, 1)) : 1'b0;
`ifdef MOTION_BG_UPDATE_EN
    bg_upd_full = upd_hold;
`endif
  endtask

  task automatic clear();
    got_q.delete(); exp_q.delete(); exp_mask_q.delete();
    upd_exp_q.delete(); upd_got_q.delete();
    fd_cnt = 0; fd_at = -1; last_mc = -1; first_rd = -1; first_wr = -1;
  endtask

  // One clock: sample on the falling edge, update the FIFO models after the rising edge.
  task automatic cyc();
    @(negedge clock);
    cyc_n++;
    s_rd = bg_rd_en;
    s_fr = fr_rd_en;
    s_wr = out_wr_en;
    chk("rd_pair", fr_rd_en, bg_rd_en);
    if (out_full) chk("wr_while_full", out_wr_en, 0);
`ifdef MOTION_BG_UPDATE_EN
    if (bg_upd_full) chk("wr_while_upd_full", out_wr_en, 0);
    chk("upd_wr_pair", bg_upd_wr_en, out_wr_en);
    if (s_wr) upd_got_q.push_back(bg_upd_din);
`endif
    if (frame_done) begin
      fd_cnt++;
      fd_at   = got_q.size();
      last_mc = int'(motion_count);
    end
    if (s_rd && first_rd < 0) first_rd = cyc_n;
    if (s_wr && first_wr < 0) first_wr = cyc_n;
    if (s_wr) got_q.push_back(out_din);
    @(posedge clock);
    #1;
    if (s_rd && bg_q.size() != 0) void'(bg_q.pop_front());
    if (s_fr && fr_q.size() != 0) void'(fr_q.pop_front());
    drive();
  endtask

  task automatic run(input int n, input int budget);
    int k = 0;
    while (got_q.size() < n && k < budget) begin
      cyc();
      k++;
    end
    chk("out_count", got_q.size(), n);
    repeat (4) cyc();
  endtask

  task automatic compare_all();
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk($sformatf("pix%0d", i), got_q[i], exp_q[i]);
  endtask

  function automatic int mask_sum(input int from, input int n);
    int s = 0;
    for (int i = from; i < from + n; i++) s += int'(exp_mask_q[i]);
    return s;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    threshold = 8'd50;
    clear();
    // frame 1: steady stream, latency and threshold boundaries
    push(24'h5A5A5A, 24'h1E1E1E);  // 90 vs 30
    push(24'h3C3C3C, 24'h1E1E1E);  // 60 vs 30
    push(24'h505050, 24'h1E1E1E);  // diff 50
    push(24'h515151, 24'h1E1E1E);  // diff 51
    push(24'h646466, 24'h323232);  // gray 100 (truncated) vs 50
    push(24'h1E1E1E, 24'h515151);  // bg brighter, diff 51
    push(24'h000000, 24'h000000);
    push(24'hFFFFFF, 24'h000000);
    drive();
    @(posedge clock);
    #1;
    chk("rst_bg_rd_en", bg_rd_en, 0);
    chk("rst_fr_rd_en", fr_rd_en, 0);
    chk("rst_out_wr_en", out_wr_en, 0);
    chk("rst_out_din", out_din, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_motion_count", motion_count, 0);
    reset = 1'b1;
    run(8, 50);
    chk("latency", first_wr - first_rd, 3);
    chk("f1_p0_hl", got_q[0], 24'hFF0000);
    chk("f1_p1_pass", got_q[1], 24'h3C3C3C);
    chk("f1_diff50", got_q[2], 24'h505050);
    chk("f1_diff51", got_q[3], 24'hFF0000);
    chk("f1_trunc", got_q[4], 24'h646466);
    chk("f1_absdiff", got_q[5], 24'hFF0000);
    chk("f1_p6", got_q[6], 24'h000000);
    chk("f1_p7", got_q[7], 24'hFF0000);
    chk("f1_fd_cnt", fd_cnt, 1);
    chk("f1_fd_at", fd_at, 8);
    chk("f1_motion", last_mc, 4);

    // frame 2: mask pattern 1,0,1,1,0,0,0,1
    clear();
    threshold = 8'd10;
    for (int i = 0; i < 8; i++)
      push((i == 0 || i == 2 || i == 3 || i == 7) ? 24'h3C3D3E : 24'h2D2D2D, 24'h282828);
    drive();
    run(8, 50);
    compare_all();
    chk("f2_p1", got_q[1], 24'h2D2D2D);
    chk("f2_fd_cnt", fd_cnt, 1);
    chk("f2_fd_at", fd_at, 8);
    chk("f2_motion", last_mc, 4);

    // frame 3: frame FIFO starved while background is available
    clear();
    hold_fr = 1;
    for (int i = 0; i < 8; i++) push({3{8'(i * 30)}}, 24'h000000);
    drive();
    repeat (5) begin
      cyc();
      chk("starve_bg_rd", s_rd, 0);
      chk("starve_fr_rd", s_fr, 0);
    end
    hold_fr = 0;
    drive();
    cyc();
    chk("unstarve_bg_rd", s_rd, 1);
    chk("unstarve_fr_rd", s_fr, 1);
    run(8, 50);
    compare_all();
    chk("f3_fd_cnt", fd_cnt, 1);
    chk("f3_motion", last_mc, 7);

    // frames 4-11: random backpressure on the output FIFO
    clear();
    threshold = 8'd40;
    bp_en = 1;
    for (int i = 0; i < 64; i++) push(24'($urandom), 24'($urandom));
    drive();
    run(64, 2000);
    bp_en = 0;
    drive();
    compare_all();
    chk("bp_fd_cnt", fd_cnt, 8);
    chk("bp_fd_at", fd_at, 64);
    chk("bp_motion", last_mc, mask_sum(56, 8));

    // reset with two pixels written and three in flight
    clear();
    threshold = 8'd10;
    for (int i = 0; i < 8; i++) push(24'h646464, 24'h000000);
    drive();
    repeat (5) cyc();
    chk("pre_rst_written", got_q.size(), 2);
    reset = 1'b0;
    #1;
    chk("mid_rst_wr_en", out_wr_en, 0);
    chk("mid_rst_bg_rd", bg_rd_en, 0);
    chk("mid_rst_fr_rd", fr_rd_en, 0);
    chk("mid_rst_din", out_din, 0);
    chk("mid_rst_fd", frame_done, 0);
    chk("mid_rst_mc", motion_count, 0);
    bg_q.delete();
    fr_q.delete();
    clear();
    drive();
    @(posedge clock);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 8; i++)
      push((i == 1 || i == 2 || i == 4) ? 24'h646464 : 24'h050505, 24'h000000);
    drive();
    run(8, 50);
    compare_all();
    chk("post_rst_fd_cnt", fd_cnt, 1);
    chk("post_rst_fd_at", fd_at, 8);
    chk("post_rst_motion", last_mc, 3);

`ifdef MOTION_BG_UPDATE_EN
    // background write-back and its backpressure
    clear();
    threshold = 8'd50;
    upd_hold = 1;
    push(24'hC8C8C8, 24'h646464);
    drive();
    repeat (6) cyc();
    chk("upd_full_blocks", got_q.size(), 0);
    upd_hold = 0;
    drive();
    run(1, 20);
    chk("upd_out", got_q[0], 24'hFF0000);
    chk("upd_din", upd_got_q[0], 24'h7D7D7D);
    chk("upd_model", upd_got_q[0], upd_exp_q[0]);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
